rvfpm_result_buffer: RTL
========================

// Module: rvfpm_result_buffer
// PURPOSE
//  Holds FPU results between pipeline writeback and the XIF result interface.
//  A result is emitted only once the core has committed its id; killed results are discarded.
//  Sits downstream of the rvfpm pipeline/queue and drives result_valid/result to the core.
//  Emission is in FPU completion order. The head entry blocks until it is committed.
// PARAMETERS
//  X_ID_WIDTH  4   width of the XIF instruction id; the commit table has 2**X_ID_WIDTH slots
//  XLEN        32  result data width
//  DEPTH       4   number of buffer entries; must be a power of 2, >=2
// PORTS
//  ck              in   1           clock, rising edge
//  rst             in   1           asynchronous reset, active-low
//  fpu_res_valid   in   1           FPU result available
//  fpu_res_ready   out  1           buffer can accept a result; equals !full
//  fpu_res_id      in   X_ID_WIDTH  id of the FPU result
//  fpu_res_data    in   XLEN        result value
//  fpu_res_rd      in   5           destination register
//  fpu_res_we      in   1           register write enable
//  fpu_res_fflags  in   5           IEEE exception flags (NV,DZ,OF,UF,NX)
//  commit_valid    in   1           XIF commit strobe
//  commit_id       in   X_ID_WIDTH  id being committed or killed
//  commit_kill     in   1           1 = kill, 0 = commit
//  result_valid    out  1           XIF result valid
//  result_ready    in   1           core accepts the result
//  result_id       out  X_ID_WIDTH  XIF result id
//  result_data     out  XLEN        XIF result data
//  result_rd       out  5           XIF result destination register
//  result_we       out  1           XIF result write enable
//  result_fflags   out  5           exception flags to be OR-ed into fcsr
// BEHAVIOUR
//  Reset (rst=0, async): buffer empty; commit table cleared; result_* = 0.
//   fpu_res_ready reads 1 once reset is released.
//  Push: when fpu_res_valid && fpu_res_ready, the result is written at the tail and count++.
//   When the buffer is full, fpu_res_ready=0 and there is no same-cycle push/pop bypass.
//  Commit table: per id, {seen, kill}. A commit_valid for an id with no buffered entry sets seen/kill.
//  A commit for an id that is already buffered sets that entry's committed or killed flag.
//   A commit and a push with the same id in the same cycle apply to the new entry.
//  At push, the table state for the id is copied into the entry and the table slot is cleared.
//  Result latency: a committed entry at the head drives result_valid on the cycle after its push.
//   The minimum push-to-result_valid latency is 1 cycle.
//  Head states:
//   EMPTY
//   WAIT    valid, not committed: result_valid=0 and the buffer stalls.
//   EMIT    committed: result_valid=1 with the head fields. The head pops when result_ready=1.
//   DROP    killed: popped silently in one cycle with result_valid=0.
//  While result_valid=1 and result_ready=0, all result_* outputs stay stable.
//   A kill for an id that is already presented as EMIT is a protocol error and is ignored.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   count is log2(DEPTH)+1 bits; full is count==DEPTH, empty is count==0.
//  Push and pop in the same cycle leave count unchanged.
//  A repeated commit for an id that is already seen is ignored (idempotent).
// STRUCTURE
//  In package in_xif:
//   typedef rb_entry_t {id, data, rd, we, fflags, committed, killed}
//   localparam RB_FFLAGS_W = 5.
//  Sub-module rvfpm_commit_table: a 2**X_ID_WIDTH x 2-bit flag array.
//   Set port: commit. Read-and-clear port: push.
//   It holds commits that arrive ahead of their results.
//  The top level contains the FIFO storage, the pointers and the head state decode.
// TESTING
//  1. Push id3 data=0x3F800000, then commit id3 on the next cycle, with result_ready=1.
//     -> result_valid one cycle later, id=3, data=0x3F800000; then empty.
//  2. Commit id5 first, then push id5 two cycles later.
//     -> result_valid on the cycle after the push.
//     -> The commit-table slot for id5 is cleared.
//  3. Push ids 1,2,3,4 with no commits.
//     -> fpu_res_ready=0 after the 4th push.
//     -> Then commit id1: result id1 emits and fpu_res_ready returns to 1.
//  4. Push id6 and id7, kill id6, commit id7.
//     -> No output for id6; id7 emits one cycle after the drop.
//  5. result_ready=0 for 5 cycles with the head committed (id2, data=0x40000000).
//     -> Outputs stay stable for all 5 cycles; pop occurs on the first cycle result_ready=1.
//  6. Assert rst=0 asynchronously mid-emit with 3 entries buffered.
//     -> result_valid=0 immediately and the buffer is empty.
//     -> After release, fpu_res_ready=1 and stale commits do not match new pushes.

Source files
------------

// File: rtl/rvfpm_result_buffer_pkg.sv
// Shared types for the rvfpm result buffer: the buffered entry layout and
// the decoded state of the buffer head.
`timescale 1ns/1ps
package in_xif;

  localparam int RB_FFLAGS_W = 5;
  localparam int RB_RD_W     = 5;
  // Entry field widths; the buffer's X_ID_WIDTH/XLEN parameters default to these.
  localparam int RB_ID_W     = 4;
  localparam int RB_XLEN     = 32;

  typedef struct packed {
    logic [RB_ID_W-1:0]     id;
    logic [RB_XLEN-1:0]     data;
    logic [RB_RD_W-1:0]     rd;
    logic                   we;
    logic [RB_FFLAGS_W-1:0] fflags;
    logic                   committed;
    logic                   killed;
  } rb_entry_t;

  typedef enum logic [1:0] {
    HEAD_EMPTY,
    HEAD_WAIT,
    HEAD_EMIT,
    HEAD_DROP
  } head_state_t;

endpackage

// File: rtl/rvfpm_result_buffer_commit_table.sv
// Per-id {seen, kill} flags for commits that arrive before their FPU result.
// Set port is the commit strobe; the push port reads the slot and clears it.
`timescale 1ns/1ps
module rvfpm_commit_table #(
  parameter int X_ID_WIDTH = 4
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  set_valid,
  input  logic [X_ID_WIDTH-1:0] set_id,
  input  logic                  set_kill,
  input  logic                  clr_valid,
  input  logic [X_ID_WIDTH-1:0] clr_id,
  output logic                  clr_seen,
  output logic                  clr_kill
);

  localparam int SLOTS = 1 << X_ID_WIDTH;

  logic [SLOTS-1:0] seen;
  logic [SLOTS-1:0] kill;

  assign clr_seen = seen[clr_id];
  assign clr_kill = kill[clr_id];

  // Record early commits once per id (repeats are ignored); a push consumes the slot
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      seen <= '0;
      kill <= '0;
    end else begin
      if (set_valid && !seen[set_id]) begin
        seen[set_id] <= 1'b1;
        kill[set_id] <= set_kill;
      end
      if (clr_valid) begin
        seen[clr_id] <= 1'b0;
        kill[clr_id] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rvfpm_result_buffer.sv
// Result buffer between the rvfpm writeback and the XIF result interface.
// Results leave in completion order; the head waits for its commit, emits
// when committed and is dropped silently when killed.
`timescale 1ns/1ps
module rvfpm_result_buffer
  import in_xif::*;
#(
  parameter int X_ID_WIDTH = RB_ID_W,
  parameter int XLEN       = RB_XLEN,
  parameter int DEPTH      = 4
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   fpu_res_valid,
  output logic                   fpu_res_ready,
  input  logic [X_ID_WIDTH-1:0]  fpu_res_id,
  input  logic [XLEN-1:0]        fpu_res_data,
  input  logic [RB_RD_W-1:0]     fpu_res_rd,
  input  logic                   fpu_res_we,
  input  logic [RB_FFLAGS_W-1:0] fpu_res_fflags,
  input  logic                   commit_valid,
  input  logic [X_ID_WIDTH-1:0]  commit_id,
  input  logic                   commit_kill,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [X_ID_WIDTH-1:0]  result_id,
  output logic [XLEN-1:0]        result_data,
  output logic [RB_RD_W-1:0]     result_rd,
  output logic                   result_we,
  output logic [RB_FFLAGS_W-1:0] result_fflags
);

  localparam int PTR_W = $clog2(DEPTH);

  rb_entry_t        mem [DEPTH];
  rb_entry_t        head;
  rb_entry_t        new_entry;
  head_state_t      head_state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             push;
  logic             pop;
  logic             emit;
  logic             commit_new;
  logic             tbl_set;
  logic             tbl_seen;
  logic             tbl_kill;
  logic [DEPTH-1:0] in_buf;
  logic [DEPTH-1:0] buf_hit;

  assign full          = (count == (PTR_W+1)'(DEPTH));
  assign fpu_res_ready = !full;
  assign push          = fpu_res_valid && !full;
  assign head          = mem[rd_ptr];

  // A commit whose id is pushed in the same cycle belongs to the new entry
  assign commit_new = commit_valid && push && (commit_id == fpu_res_id);

  // Decode which slots are occupied and which buffered entry a commit targets
  always_comb begin
    in_buf  = '0;
    buf_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      in_buf[i]  = ({1'b0, PTR_W'(i) - rd_ptr} < count);
      buf_hit[i] = commit_valid && !commit_new && in_buf[i] && (mem[i].id == commit_id);
    end
  end

  // Commits for ids not yet buffered are parked in the commit table
  assign tbl_set = commit_valid && !commit_new && !(|buf_hit);

  rvfpm_commit_table #(
    .X_ID_WIDTH (X_ID_WIDTH)
  ) u_commit_table (
    .ck        (ck),
    .rst       (rst),
    .set_valid (tbl_set),
    .set_id    (commit_id),
    .set_kill  (commit_kill),
    .clr_valid (push),
    .clr_id    (fpu_res_id),
    .clr_seen  (tbl_seen),
    .clr_kill  (tbl_kill)
  );

  // Build the pushed entry; a parked commit wins over a same-cycle one (idempotence)
  always_comb begin
    new_entry           = '0;
    new_entry.id        = fpu_res_id;
    new_entry.data      = fpu_res_data;
    new_entry.rd        = fpu_res_rd;
    new_entry.we        = fpu_res_we;
    new_entry.fflags    = fpu_res_fflags;
    new_entry.committed = tbl_seen ? !tbl_kill : (commit_new && !commit_kill);
    new_entry.killed    = tbl_seen ?  tbl_kill : (commit_new &&  commit_kill);
  end

  // Head decode: kill beats commit, and a committed entry ignores later kills
  always_comb begin
    head_state = HEAD_EMPTY;
    if (count != '0) begin
      if (head.killed)         head_state = HEAD_DROP;
      else if (head.committed) head_state = HEAD_EMIT;
      else                     head_state = HEAD_WAIT;
    end
  end

  assign emit = (head_state == HEAD_EMIT);
  assign pop  = (emit && result_ready) || (head_state == HEAD_DROP);

  // Write pushed results and fold commits into entries that are still undecided
  always_ff @(posedge ck) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (buf_hit[i] && !mem[i].committed && !mem[i].killed) begin
        mem[i].committed <= !commit_kill;
        mem[i].killed    <= commit_kill;
      end
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Result fields are zero unless the head is being presented
  always_comb begin
    result_valid  = emit;
    result_id     = emit ? head.id     : '0;
    result_data   = emit ? head.data   : '0;
    result_rd     = emit ? head.rd     : '0;
    result_we     = emit ? head.we     : 1'b0;
    result_fflags = emit ? head.fflags : '0;
  end

endmodule
